// File: rtl/fln_range_reduce_if.sv
// Valid/ready operand and result bundle for the fln range-reduction stage.
`timescale 1ns/1ps
interface fln_range_reduce_if #(
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_mant;
    logic [8:0]       out_k;
    logic             out_special;
    logic [31:0]      out_spval;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_data, in_tag, out_ready,
        input  in_ready, out_valid, out_mant, out_k,
        input  out_special, out_spval, out_tag
    );

    modport slave (
        input  in_valid, in_data, in_tag, out_ready,
        output in_ready, out_valid, out_mant, out_k,
        output out_special, out_spval, out_tag
    );
endinterface

// File: rtl/fln_range_reduce.sv
// Two-stage float32 range reduction for ln: x = m * 2^k, m near 1.0.
// S1 classifies and normalises denormals, S2 splits at sqrt(2).
`timescale 1ns/1ps
module fln_range_reduce #(
    parameter int          TAG_W      = 4,
    parameter logic [22:0] SPLIT_FRAC = 23'h3504F3
) (
    input  logic             clk,
    input  logic             rst_n,
    fln_range_reduce_if.slave bus
);
    typedef struct packed {
        logic             sp;
        logic [31:0]      spval;
        logic [22:0]      frac;
        logic [8:0]       k0;
        logic [TAG_W-1:0] tag;
    } s1_t;

    logic        w_s;
    logic [7:0]  w_e;
    logic [22:0] w_f;
    logic [4:0]  w_lz;
    logic        w_found;
    s1_t         w_s1;
    s1_t         r_s1;
    logic        r_s1_v;
    logic        r_s2_v;
    logic        w_s1_load;
    logic        w_s2_load;
    logic        w_ge;
    logic [31:0] w_mant;
    logic [8:0]  w_k;

    assign w_s = bus.in_data[31];
    assign w_e = bus.in_data[30:23];
    assign w_f = bus.in_data[22:0];

    always_comb begin
        w_lz    = 5'd0;
        w_found = 1'b0;
        for (int i = 22; i >= 0; i--) begin
            if (!w_found) begin
                if (w_f[i]) w_found = 1'b1;
                else        w_lz    = w_lz + 5'd1;
            end
        end
    end

    always_comb begin
        w_s1.sp    = 1'b0;
        w_s1.spval = 32'h0;
        w_s1.frac  = w_f;
        w_s1.k0    = {1'b0, w_e} - 9'd127;
        w_s1.tag   = bus.in_tag;
        if (w_e == 8'hFF && w_f != 23'd0) begin
            w_s1.sp    = 1'b1;
            w_s1.spval = 32'h7FC00000;
        end else if (w_s && (w_e != 8'd0 || w_f != 23'd0)) begin
            w_s1.sp    = 1'b1;
            w_s1.spval = 32'h7FC00000;
        end else if (w_e == 8'd0 && w_f == 23'd0) begin
            w_s1.sp    = 1'b1;
            w_s1.spval = 32'hFF800000;
        end else if (w_e == 8'hFF) begin
            w_s1.sp    = 1'b1;
            w_s1.spval = 32'h7F800000;
        end else if (w_e == 8'd0) begin
            // drop the leading one so frac is the implicit-one fraction
            w_s1.frac = w_f << (w_lz + 5'd1);
            w_s1.k0   = 9'h181 - {4'd0, w_lz};
        end
    end

    assign w_s2_load  = !r_s2_v || bus.out_ready;
    assign w_s1_load  = !r_s1_v || w_s2_load;
    assign bus.in_ready = w_s1_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_v <= 1'b0;
            r_s1   <= '0;
        end else if (w_s1_load) begin
            r_s1_v <= bus.in_valid;
            if (bus.in_valid) r_s1 <= w_s1;
        end
    end

    assign w_ge = r_s1.frac >= SPLIT_FRAC;

    always_comb begin
        w_mant = {1'b0, 8'h7F, r_s1.frac};
        w_k    = r_s1.k0;
        if (r_s1.sp) begin
            w_mant = 32'h3F800000;
            w_k    = 9'd0;
        end else if (w_ge) begin
            w_mant = {1'b0, 8'h7E, r_s1.frac};
            w_k    = r_s1.k0 + 9'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_v          <= 1'b0;
            bus.out_mant    <= 32'h0;
            bus.out_k       <= 9'd0;
            bus.out_special <= 1'b0;
            bus.out_spval   <= 32'h0;
            bus.out_tag     <= '0;
        end else if (w_s2_load) begin
            r_s2_v <= r_s1_v;
            if (r_s1_v) begin
                bus.out_mant    <= w_mant;
                bus.out_k       <= w_k;
                bus.out_special <= r_s1.sp;
                bus.out_spval   <= r_s1.spval;
                bus.out_tag     <= r_s1.tag;
            end
        end
    end

    assign bus.out_valid = r_s2_v;
endmodule

// File: tb/tb_fln_range_reduce.sv
// Directed bench for fln_range_reduce: value model plus in-order scoreboard.
`timescale 1ns/1ps
module tb_fln_range_reduce;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fln_range_reduce_if #(.TAG_W(4)) bus ();
    fln_range_reduce #(.TAG_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] mant;
        logic [8:0]  k;
        logic        sp;
        logic [31:0] spval;
        logic [3:0]  tag;
    } exp_t;

    exp_t q[$];
    exp_t cur, prev, ex;
    logic prev_stall = 1'b0;
    int   errs = 0, checks = 0;
    int   acc_cnt = 0, out_cnt = 0, cyc = 0;
    logic [3:0] last_tag = 4'd0;

    task automatic chk(string name, logic [95:0] act, logic [95:0] req);
        checks++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Reference: value = 1.f * 2^k0, then fold m into [sqrt2/2, sqrt2)
    function automatic exp_t model(logic [31:0] x, logic [3:0] tag);
        exp_t r;
        int   e, f, k0, fr, p;
        e = int'(x[30:23]);
        f = int'(x[22:0]);
        r.tag = tag;
        r.sp = 1'b1;
        r.mant = 32'h3F800000;
        r.k = 9'd0;
        if (e == 255 && f != 0)            r.spval = 32'h7FC00000;
        else if (x[31] && x[30:0] != 0)    r.spval = 32'h7FC00000;
        else if (x[30:0] == 0)             r.spval = 32'hFF800000;
        else if (e == 255)                 r.spval = 32'h7F800000;
        else begin
            r.sp = 1'b0;
            r.spval = 32'h0;
            if (e != 0) begin
                k0 = e - 127;
                fr = f;
            end else begin
                p = 0;
                for (int i = 0; i < 23; i++) if (x[i]) p = i;
                k0 = p - 149;
                fr = (f - (1 << p)) << (23 - p);
            end
            if (fr >= 32'h3504F3) begin
                r.mant = {1'b0, 8'h7E, fr[22:0]};
                k0 = k0 + 1;
            end else begin
                r.mant = {1'b0, 8'h7F, fr[22:0]};
            end
            r.k = k0[8:0];
        end
        return r;
    endfunction

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            prev_stall = 1'b0;
        end else begin
            cur = {bus.out_mant, bus.out_k, bus.out_special,
                   bus.out_spval, bus.out_tag};
            if (prev_stall) begin
                chk("hold_valid", 96'(bus.out_valid), 96'd1);
                chk("hold_data", 96'(cur), 96'(prev));
            end
            if (bus.out_valid && bus.out_ready) begin
                out_cnt++;
                last_tag = bus.out_tag;
                if (q.size() == 0) chk("spurious_out", 96'd1, 96'd0);
                else begin
                    ex = q.pop_front();
                    chk("result", 96'(cur), 96'(ex));
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                acc_cnt++;
                q.push_back(model(bus.in_data, bus.in_tag));
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev = cur;
        end
    end

    task automatic send(logic [31:0] x, logic [3:0] tag);
        bus.in_valid = 1'b1;
        bus.in_data = x;
        bus.in_tag = tag;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                @(posedge clk);
                #1;
                bus.in_valid = 1'b0;
                return;
            end
        end
        chk("send_timeout", 96'd0, 96'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 200; n++) begin
            if (q.size() == 0 && !bus.out_valid) break;
            @(negedge clk);
        end
        chk("drain", 96'(q.size()), 96'd0);
        @(posedge clk);
        #1;
    endtask

    localparam int NV = 13;
    logic [31:0] vx [NV] = '{
        32'h40000000, 32'h3FC00000, 32'h3FB504F2, 32'h3FB504F3,
        32'h3F800000, 32'h00000001, 32'h00400000, 32'h80000000,
        32'h00000000, 32'hBF800000, 32'h7FC00001, 32'h7F800000,
        32'h7F7FFFFF};
    logic [31:0] vm [NV] = '{
        32'h3F800000, 32'h3F400000, 32'h3FB504F2, 32'h3F3504F3,
        32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
        32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
        32'h3F7FFFFF};
    logic [8:0] vk [NV] = '{
        9'd1, 9'd1, 9'd0, 9'd1, 9'd0, 9'h16B, 9'h181,
        9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'h080};
    logic [31:0] vs [NV] = '{
        32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
        32'hFF800000, 32'hFF800000, 32'h7FC00000, 32'h7FC00000,
        32'h7F800000, 32'h0};

    initial begin
        int a0, o0, c0;
        exp_t lit, mdl;
        bus.in_valid = 1'b0;
        bus.in_data = 32'h0;
        bus.in_tag = 4'd0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 96'(bus.out_valid), 96'd0);
        chk("rst_out_mant", 96'(bus.out_mant), 96'd0);
        chk("rst_out_k", 96'(bus.out_k), 96'd0);
        chk("rst_out_special", 96'(bus.out_special), 96'd0);
        chk("rst_out_spval", 96'(bus.out_spval), 96'd0);
        chk("rst_out_tag", 96'(bus.out_tag), 96'd0);
        rst_n = 1'b1;
        chk("rst_in_ready", 96'(bus.in_ready), 96'd1);

        for (int i = 0; i < NV; i++) begin
            lit.mant = vm[i];
            lit.k = vk[i];
            lit.sp = (vs[i] != 32'h0);
            lit.spval = vs[i];
            lit.tag = 4'(i);
            mdl = model(vx[i], 4'(i));
            chk("model_pin", 96'(mdl), 96'(lit));
        end

        bus.out_ready = 1'b1;
        c0 = cyc;
        for (int i = 0; i < NV; i++) send(vx[i], 4'(i));
        chk("throughput_cycles", 96'(cyc - c0), 96'(NV));
        drain();
        chk("directed_count", 96'(out_cnt), 96'(NV));

        a0 = acc_cnt;
        o0 = out_cnt;
        bus.out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 5; i++)
                    send(32'h3F800000 + 32'(i) * 32'h00100000, 4'(i));
            end
            begin
                repeat (4) @(posedge clk);
                #2;
                chk("bp_accepts", 96'(acc_cnt - a0), 96'd2);
                chk("bp_in_ready", 96'(bus.in_ready), 96'd0);
                bus.out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_delivered", 96'(out_cnt - o0), 96'd5);
        chk("bp_last_tag", 96'(last_tag), 96'd4);

        bus.out_ready = 1'b0;
        send(32'h40400000, 4'd7);
        send(32'h40800000, 4'd8);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", 96'(bus.out_valid), 96'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_mid_in_ready", 96'(bus.in_ready), 96'd1);
        o0 = out_cnt;
        bus.out_ready = 1'b1;
        send(32'h40000000, 4'd9);
        drain();
        chk("rst_mid_count", 96'(out_cnt - o0), 96'd1);
        chk("rst_mid_tag", 96'(last_tag), 96'd9);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
